// File: rtl/core_pkg.sv
// Shared load/store encodings, FSM state type and alignment helpers for the
// memory stage.
package core_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

  // funct3 = 111 has no legal size, so it is reported as misaligned.
  function automatic logic lsu_aligned(input logic [2:0] f3, input logic [2:0] off);
    logic ok;
    case (f3)
      LSU_B, LSU_BU:  ok = 1'b1;
      LSU_H, LSU_HU:  ok = (off[0] == 1'b0);
      LSU_W, LSU_WU:  ok = (off[1:0] == 2'b00);
      LSU_D:          ok = (off == 3'b000);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] lsu_size_mask(input logic [2:0] f3);
    logic [7:0] m;
    case (f3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction: shifts the addressed lanes down to bit 0,
// truncates to the access size and sign- or zero-extends.
module load_align
  import core_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      LSU_B:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LSU_H:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LSU_W:   data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LSU_BU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LSU_HU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LSU_WU:  data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results to write-back, or runs one
// load/store on the data-memory bus while stalling upstream.
module mem_stage
  import core_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic            write_back_i,
  input  logic            load_flag_i,
  input  logic            mem_en_i,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            stall_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            wb_en_o,
  output logic [4:0]      rd_o,
  output logic            misalign_o,
  output mem_state_e      state_o
);

  // Bus handshake: mem_req rises the edge after an aligned memory op is
  // accepted and, with mem_we/addr/wdata/wstrb, holds until the cycle mem_ack
  // is sampled high; that edge completes the transfer and drops mem_req.
  // mem_ack outside a request is ignored. Reset may drop mem_req without ack.
  mem_state_e      state_q;
  logic            mem_req_q, mem_we_q, wb_en_q, misalign_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
  logic [7:0]      mem_wstrb_q;
  logic [4:0]      rd_q;
  logic [2:0]      off_q, f3_q;
  logic            aligned;
  logic [XLEN-1:0] load_val;

  assign aligned = lsu_aligned(funct3_i, alu_res_i[2:0]);
  assign stall_o = (state_q == MEM_IDLE) ? (mem_en_i && aligned) : !mem_ack;

  load_align u_load_align (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (load_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= MEM_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 8'h00;
      wb_data_q   <= '0;
      wb_en_q     <= 1'b0;
      rd_q        <= 5'd0;
      misalign_q  <= 1'b0;
      off_q       <= 3'd0;
      f3_q        <= 3'd0;
    end else begin
      misalign_q <= 1'b0;
      wb_en_q    <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          rd_q <= rd_i;
          if (!mem_en_i) begin
            wb_data_q <= alu_res_i;
            wb_en_q   <= write_back_i && (rd_i != 5'd0);
          end else if (!aligned) begin
            misalign_q <= 1'b1;
          end else begin
            state_q     <= MEM_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= !load_flag_i;
            mem_addr_q  <= {alu_res_i[XLEN-1:3], 3'b000};
            mem_wdata_q <= store_data_i << {alu_res_i[2:0], 3'b000};
            mem_wstrb_q <= load_flag_i ? 8'hFF
                                       : (lsu_size_mask(funct3_i) << alu_res_i[2:0]);
            off_q       <= alu_res_i[2:0];
            f3_q        <= funct3_i;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            state_q     <= MEM_IDLE;
            mem_req_q   <= 1'b0;
            mem_wstrb_q <= 8'h00;
            rd_q        <= rd_i;
            if (!mem_we_q) begin
              wb_data_q <= load_val;
              wb_en_q   <= write_back_i && (rd_i != 5'd0);
            end
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign wb_data_o  = wb_data_q;
  assign wb_en_o    = wb_en_q;
  assign rd_o       = rd_q;
  assign misalign_o = misalign_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus lightly randomised bench for mem_stage; write-back values are
// queued when an op is issued and compared when wb_en_o fires.
module tb_mem_stage;
  import core_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] alu_res_i, store_data_i, mem_rdata;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        write_back_i, load_flag_i, mem_en_i, mem_ack;
  logic        mem_req, mem_we, stall_o, wb_en_o, misalign_o;
  logic [63:0] mem_addr, mem_wdata, wb_data_o;
  logic [7:0]  mem_wstrb;
  logic [4:0]  rd_o;
  mem_state_e  state_o;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .CLK(CLK), .RST(RST), .alu_res_i(alu_res_i), .store_data_i(store_data_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .write_back_i(write_back_i),
    .load_flag_i(load_flag_i), .mem_en_i(mem_en_i), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_o(stall_o), .wb_data_o(wb_data_o), .wb_en_o(wb_en_o), .rd_o(rd_o),
    .misalign_o(misalign_o), .state_o(state_o)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sb_check(input string tag);
    if (wb_en_o === 1'b1) begin
      if (exp_q.size() == 0) chk({tag, "_unexpected_wb"}, 64'(wb_en_o), 64'd0);
      else chk({tag, "_wb_data"}, wb_data_o, exp_q.pop_front());
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] rdat, input logic [2:0] off,
                                             input logic [2:0] f3);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdat[8*(int'(off)+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // One memory op: accept, `waits` REQ cycles without ack, then ack.
  task automatic mem_op(input string tag, input logic [63:0] ea, input logic [2:0] f3,
                        input logic ld, input logic [63:0] sdata, input logic [63:0] rdat,
                        input int waits, input logic [4:0] rd, input logic [63:0] e_addr,
                        input logic [7:0] e_strb, input logic [63:0] e_wdata,
                        input logic [63:0] e_wb);
    int stalls = 0;
    alu_res_i = ea; funct3_i = f3; load_flag_i = ld; store_data_i = sdata;
    rd_i = rd; write_back_i = 1'b1; mem_en_i = 1'b1; mem_ack = 1'b0;
    #1;
    if (stall_o === 1'b1) stalls++;
    if (ld) exp_q.push_back(e_wb);
    step();
    chk({tag, "_req"}, 64'(mem_req), 64'd1);
    chk({tag, "_we"}, 64'(mem_we), 64'(!ld));
    chk({tag, "_addr"}, mem_addr, e_addr);
    chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'(e_strb));
    chk({tag, "_wdata"}, mem_wdata, e_wdata);
    chk({tag, "_bubble"}, 64'(wb_en_o), 64'd0);
    for (int w = 0; w < waits; w++) begin
      if (stall_o === 1'b1) stalls++;
      step();
      chk({tag, "_req_hold"}, 64'(mem_req), 64'd1);
    end
    mem_ack = 1'b1; mem_rdata = rdat;
    #1;
    if (stall_o === 1'b1) stalls++;
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(waits + 1));
    step();
    mem_ack = 1'b0; mem_en_i = 1'b0; write_back_i = 1'b0; mem_rdata = '0;
    #1;
    chk({tag, "_req_done"}, 64'(mem_req), 64'd0);
    chk({tag, "_wstrb_done"}, 64'(mem_wstrb), 64'd0);
    chk({tag, "_state_idle"}, 64'(state_o), 64'(MEM_IDLE));
    chk({tag, "_wb_en"}, 64'(wb_en_o), 64'(ld));
    chk({tag, "_rd"}, 64'(rd_o), 64'(rd));
    sb_check(tag);
  endtask

  initial begin
    // reset
    RST = 1'b1; alu_res_i = '0; store_data_i = '0; mem_rdata = '0; funct3_i = '0;
    rd_i = '0; write_back_i = 1'b0; load_flag_i = 1'b0; mem_en_i = 1'b0; mem_ack = 1'b0;
    step(); step();
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_wb_en", 64'(wb_en_o), 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_rd", 64'(rd_o), 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_state", 64'(state_o), 64'(MEM_IDLE));
    RST = 1'b0;

    // pass-through
    alu_res_i = 64'h1234; rd_i = 5'd5; write_back_i = 1'b1; mem_en_i = 1'b0;
    #1;
    chk("pt_stall", 64'(stall_o), 64'd0);
    exp_q.push_back(64'h1234);
    step();
    chk("pt_wb_en", 64'(wb_en_o), 64'd1);
    chk("pt_rd", 64'(rd_o), 64'd5);
    sb_check("pt");

    // rd = 0 suppresses write-back
    alu_res_i = 64'h5555; rd_i = 5'd0; write_back_i = 1'b1;
    step();
    chk("rd0_wb_en", 64'(wb_en_o), 64'd0);
    write_back_i = 1'b0;

    // ack in IDLE is ignored
    mem_ack = 1'b1;
    step();
    chk("idle_ack_req", 64'(mem_req), 64'd0);
    chk("idle_ack_state", 64'(state_o), 64'(MEM_IDLE));
    mem_ack = 1'b0;

    // directed loads and stores
    mem_op("lb", 64'h1003, LSU_B, 1'b1, 64'd0, 64'h00000000_80000000, 3, 5'd7,
           64'h1000, 8'hFF, 64'd0, 64'hFFFFFFFF_FFFFFF80);
    mem_op("lwu", 64'h2004, LSU_WU, 1'b1, 64'd0, 64'hDEADBEEF_00000000, 1, 5'd8,
           64'h2000, 8'hFF, 64'd0, 64'h00000000_DEADBEEF);
    mem_op("sh", 64'h3006, LSU_H, 1'b0, 64'hABCD, 64'd0, 2, 5'd9,
           64'h3000, 8'hC0, 64'hABCD0000_00000000, 64'd0);
    mem_op("ld", 64'h5000, LSU_D, 1'b1, 64'd0, 64'h01234567_89ABCDEF, 0, 5'd10,
           64'h5000, 8'hFF, 64'd0, 64'h01234567_89ABCDEF);
    mem_op("lh", 64'h6002, LSU_H, 1'b1, 64'd0, 64'h00000000_80010000, 0, 5'd11,
           64'h6000, 8'hFF, 64'd0, 64'hFFFFFFFF_FFFF8001);
    mem_op("lw", 64'h7004, LSU_W, 1'b1, 64'd0, 64'h80000000_00000000, 1, 5'd12,
           64'h7000, 8'hFF, 64'd0, 64'hFFFFFFFF_80000000);

    // misaligned doubleword load
    alu_res_i = 64'h4004; funct3_i = LSU_D; load_flag_i = 1'b1; mem_en_i = 1'b1;
    rd_i = 5'd3; write_back_i = 1'b1;
    #1;
    chk("mis_stall", 64'(stall_o), 64'd0);
    step();
    chk("mis_pulse", 64'(misalign_o), 64'd1);
    chk("mis_req", 64'(mem_req), 64'd0);
    chk("mis_wb_en", 64'(wb_en_o), 64'd0);
    mem_en_i = 1'b0; write_back_i = 1'b0;
    step();
    chk("mis_pulse_end", 64'(misalign_o), 64'd0);
    chk("mis_req_after", 64'(mem_req), 64'd0);

    // funct3 = 111 is misaligned
    alu_res_i = 64'h0; funct3_i = 3'b111; mem_en_i = 1'b1;
    step();
    chk("f7_pulse", 64'(misalign_o), 64'd1);
    chk("f7_req", 64'(mem_req), 64'd0);
    mem_en_i = 1'b0;

    // reset mid-transaction
    alu_res_i = 64'h8000; funct3_i = LSU_D; load_flag_i = 1'b1; mem_en_i = 1'b1; rd_i = 5'd4;
    step(); step();
    chk("rmid_req_before", 64'(mem_req), 64'd1);
    RST = 1'b1; mem_en_i = 1'b0;
    step();
    RST = 1'b0;
    #1;
    chk("rmid_req", 64'(mem_req), 64'd0);
    chk("rmid_stall", 64'(stall_o), 64'd0);
    chk("rmid_state", 64'(state_o), 64'(MEM_IDLE));
    mem_op("rmid_ld", 64'h8008, LSU_D, 1'b1, 64'd0, 64'hCAFEF00D_12345678, 1, 5'd4,
           64'h8008, 8'hFF, 64'd0, 64'hCAFEF00D_12345678);

    // randomised loads
    for (int k = 0; k < 6; k++) begin
      logic [2:0] f3, off;
      logic [63:0] ea, rdat;
      int n;
      f3 = 3'($urandom_range(0, 6));
      n = 1 << f3[1:0];
      off = 3'($urandom_range(0, 7)) & ~3'(n - 1);
      ea = {32'($urandom), 32'($urandom)};
      ea[2:0] = off;
      rdat = {32'($urandom), 32'($urandom)};
      mem_op($sformatf("rld%0d", k), ea, f3, 1'b1, 64'd0, rdat, $urandom_range(0, 2),
             5'($urandom_range(1, 31)), {ea[63:3], 3'b000}, 8'hFF, 64'd0,
             model_load(rdat, off, f3));
    end

    // randomised stores
    for (int k = 0; k < 4; k++) begin
      logic [2:0] f3, off;
      logic [63:0] ea, sdata;
      logic [7:0] strb;
      int n;
      f3 = 3'($urandom_range(0, 3));
      n = 1 << f3[1:0];
      off = 3'($urandom_range(0, 7)) & ~3'(n - 1);
      ea = {32'($urandom), 32'($urandom)};
      ea[2:0] = off;
      sdata = {32'($urandom), 32'($urandom)};
      strb = 8'h00;
      for (int i = 0; i < n; i++) strb[int'(off) + i] = 1'b1;
      mem_op($sformatf("rst%0d", k), ea, f3, 1'b0, sdata, 64'd0, $urandom_range(0, 2),
             5'($urandom_range(1, 31)), {ea[63:3], 3'b000}, strb,
             sdata << (8 * int'(off)), 64'd0);
    end

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute/ALU stage; consumes its registered result, rd, write-back enable, load flag and memory enable.
- Non-memory ops pass through to write-back with a one-cycle register delay.
- Loads and stores drive a 64-bit req/ack data-memory bus and stall upstream until the bus acknowledges.
- Handles byte-lane alignment, store strobes, load sign/zero extension, and misalignment detection.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- alu_res_i  in  64  ALU result; effective address for memory ops.
- store_data_i  in  64  rs2 value for stores.
- funct3_i  in  3  access size and sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- rd_i  in  5  destination register.
- write_back_i  in  1  ALU write-back enable.
- load_flag_i  in  1  with mem_en_i: 1 = load, 0 = store.
- mem_en_i  in  1  memory op present.
- mem_req  out  1  bus request; held until ack.
- mem_we  out  1  1 = store.
- mem_addr  out  64  doubleword-aligned address, {ea[63:3], 3'b000}.
- mem_wdata  out  64  lane-shifted store data.
- mem_wstrb  out  8  byte enables.
- mem_rdata  in  64  read doubleword; valid when mem_ack=1.
- mem_ack  in  1  completes the outstanding request.
- stall_o  out  1  freezes the ALU stage and everything upstream; combinational.
- wb_data_o  out  64  write-back value.
- wb_en_o  out  1  write-back enable.
- rd_o  out  5  write-back destination.
- misalign_o  out  1  one-cycle pulse for a misaligned access.

Behaviour:
- Reset: while RST=1 at an edge, state goes to IDLE, and mem_req, mem_we, mem_wstrb, wb_en_o, misalign_o, rd_o, wb_data_o, mem_addr and mem_wdata all go to 0.
- Reset mid-transaction abandons the request. The bus must tolerate mem_req falling without an ack.
- FSM states are IDLE and REQ.
- Alignment: ea = alu_res_i. An access is aligned when its low address bits are zero for its size (H: bit0; W/WU: bits 1:0; D: bits 2:0). B is always aligned. funct3=111 with mem_en_i is treated as misaligned.
- IDLE, mem_en_i=0: next edge sets wb_data_o=alu_res_i, wb_en_o=write_back_i, rd_o=rd_i (1-cycle latency). stall_o=0.
- IDLE, mem_en_i=1, misaligned: no bus access. Next edge sets misalign_o=1 and wb_en_o=0. stall_o=0.
- IDLE, mem_en_i=1, aligned: stall_o=1. Next edge sets:
  - state=REQ, mem_req=1, mem_we=!load_flag_i, mem_addr as above;
  - mem_wdata = store_data_i << (8*ea[2:0]);
  - mem_wstrb = size mask << ea[2:0] for stores, 8'hFF for loads;
  - wb_en_o=0 (bubble).
- REQ: stall_o = !mem_ack. Upstream inputs are held stable by the stall.
- REQ, mem_ack=1: next edge sets state=IDLE, mem_req=0, mem_wstrb=0, rd_o=rd_i.
  - Load: wb_en_o=write_back_i. wb_data_o is (mem_rdata >> 8*ea[2:0]) truncated to the access size, then sign-extended for B/H/W/D and zero-extended for BU/HU/WU.
  - Store: wb_en_o=0.
- REQ, mem_ack=0: mem_req and all bus outputs hold; wb_en_o=0.
- Minimum memory-op latency is 2 cycles (accept, ack). Back-to-back memory ops re-enter REQ the cycle after return to IDLE; there is no combinational req→ack path.
- rd_o=0 forces wb_en_o=0.
- mem_ack while in IDLE is ignored.

Decomposition:
- Shared package (core_pkg) holds:
  - funct3 size encodings (LSU_B, LSU_H, LSU_W, LSU_D, LSU_BU, LSU_HU, LSU_WU);
  - state encoding MEM_IDLE/MEM_REQ;
  - XLEN.
- One natural sub-module, load_align: purely combinational. Takes rdata, offset and funct3, returns the extended 64-bit value. It is unit-testable separately.
- Store lane shifting and strobe generation stay inline.

Test Plan:
- Pass-through: mem_en_i=0, alu_res_i=64'h1234, rd_i=5, write_back_i=1 → next cycle wb_data_o=64'h1234, rd_o=5, wb_en_o=1; stall_o never high.
- Signed byte load: ea=64'h1003, funct3=000; ack after 3 wait cycles with mem_rdata=64'h00000000_80000000 → mem_addr=64'h1000; stall_o high for 4 cycles; wb_data_o=64'hFFFFFFFF_FFFFFF80, wb_en_o=1.
- Unsigned word load: ea=64'h2004, funct3=110, rdata=64'hDEADBEEF_00000000 → wb_data_o=64'h00000000_DEADBEEF.
- Halfword store: ea=64'h3006, funct3=001, store_data_i=64'hABCD → mem_we=1, mem_wstrb=8'hC0, mem_wdata=64'hABCD0000_00000000; wb_en_o=0 after ack.
- Misaligned doubleword load: ea=64'h4004, funct3=011 → mem_req stays 0, misalign_o pulses 1 cycle, stall_o=0.
- Reset mid-op: RST=1 while in REQ with no ack → next cycle mem_req=0, stall_o=0, state IDLE; a following load completes normally.
